// File: rtl/delay_line_param_pkg.sv
// Shared EMD signal-path definitions: default widths/delays and the delay clamp.
package delay_line_param_pkg;

    localparam int EMD_DATA_W    = 16;
    localparam int EMD_DEF_DLY   = 120;
    localparam int EMD_MAX_DEPTH = 128;

    // A requested delay of 0 is treated as 1; anything beyond the buffer saturates.
    function automatic int unsigned clamp_dly(input int unsigned len, input int unsigned max_depth);
        int unsigned res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else if (len > max_depth) begin
            res = max_depth;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/delay_line_param_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, read-before-write.
module delay_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-address write lands after this read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/delay_line_param.sv
// Runtime-programmable sample delay line on a circular buffer, zero-gated until primed.
module delay_line_param
    import delay_line_param_pkg::*;
#(
    parameter int DATA_W    = EMD_DATA_W,
    parameter int MAX_DEPTH = EMD_MAX_DEPTH,
    parameter int DEF_DLY   = EMD_DEF_DLY,
    parameter int CNT_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Xin,
    input  logic              Xin_VALID,
    input  logic [CNT_W-1:0]  DLY_LEN,
    input  logic              DLY_LOAD,
    output logic [DATA_W-1:0] Xout,
    output logic              Xout_VALID,
    output logic              PRIMED,
    output logic [CNT_W-1:0]  DLY_CUR
);

    localparam int AW = $clog2(MAX_DEPTH);
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(MAX_DEPTH);
    localparam logic [AW-1:0]  LAST_PTR  = AW'(MAX_DEPTH - 1);

    logic [AW-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]  fill_cnt_r;
    logic [CNT_W-1:0]  dly_cur_r;
    logic              primed_r;
    logic              gate_r;
    logic              xout_valid_r;
    logic [DATA_W-1:0] rd_data_s;

    logic [CNT_W-1:0]  d_eff_s;
    logic [CNT_W-1:0]  fill_eff_s;
    logic [CNT_W-1:0]  fill_next_s;
    logic              gate_s;
    logic [CNT_W:0]    wr_ext_s;
    logic [CNT_W:0]    d_ext_s;
    logic [CNT_W:0]    rd_ext_s;
    logic [AW-1:0]     rd_addr_s;
    logic [AW-1:0]     wr_ptr_next_s;
    logic              ram_en_s;

    // A load takes effect on the same cycle's sample, with the fill count restarted.
    always_comb begin
        d_eff_s    = dly_cur_r;
        fill_eff_s = fill_cnt_r;
        if (DLY_LOAD) begin
            d_eff_s    = CNT_W'(clamp_dly(32'(DLY_LEN), 32'(MAX_DEPTH)));
            fill_eff_s = '0;
        end else begin
            d_eff_s    = dly_cur_r;
            fill_eff_s = fill_cnt_r;
        end

        gate_s = (fill_eff_s >= d_eff_s);
        if (gate_s) begin
            fill_next_s = d_eff_s;
        end else begin
            fill_next_s = fill_eff_s + CNT_W'(1'b1);
        end

        wr_ext_s = (CNT_W + 1)'(wr_ptr_r);
        d_ext_s  = (CNT_W + 1)'(d_eff_s);
        if (wr_ext_s >= d_ext_s) begin
            rd_ext_s = wr_ext_s - d_ext_s;
        end else begin
            rd_ext_s = wr_ext_s + DEPTH_EXT - d_ext_s;
        end
        rd_addr_s = AW'(rd_ext_s);

        if (wr_ptr_r == LAST_PTR) begin
            wr_ptr_next_s = '0;
        end else begin
            wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
        end

        ram_en_s = Xin_VALID && !RST;
    end

    delay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (ram_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (Xin),
        .rd_en   (ram_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Pointer, fill counter, delay register and output gating state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r     <= '0;
            fill_cnt_r   <= '0;
            dly_cur_r    <= CNT_W'(DEF_DLY);
            primed_r     <= 1'b0;
            gate_r       <= 1'b0;
            xout_valid_r <= 1'b0;
        end else begin
            xout_valid_r <= Xin_VALID;
            if (DLY_LOAD) begin
                dly_cur_r <= d_eff_s;
            end
            if (Xin_VALID) begin
                wr_ptr_r   <= wr_ptr_next_s;
                fill_cnt_r <= fill_next_s;
                primed_r   <= gate_s;
                gate_r     <= gate_s;
            end else if (DLY_LOAD) begin
                fill_cnt_r <= '0;
                primed_r   <= 1'b0;
            end
        end
    end

    // gate_r only changes with the RAM read register, so Xout holds across idle cycles.
    always_comb begin
        if (gate_r) begin
            Xout = rd_data_s;
        end else begin
            Xout = '0;
        end
    end

    assign Xout_VALID = xout_valid_r;
    assign PRIMED     = primed_r;
    assign DLY_CUR    = dly_cur_r;

endmodule

// File: tb/tb_delay_line_param.sv
// Bench for delay_line_param: sample-history model for a 128-deep and a 100-deep instance.
module tb_delay_line_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic               RST;
    logic signed [15:0] xin;
    logic               xin_valid;
    logic [7:0]         dly_len;
    logic               dly_load;

    logic signed [15:0] xout_w   [2];
    logic               xvalid_w [2];
    logic               primed_w [2];
    logic [7:0]         dly_cur_w[2];

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int M   = (g == 0) ? 128 : 100;
        localparam int DEF = (g == 0) ? 120 : 100;
        localparam int CW  = $clog2(M + 1);

        logic [CW-1:0] dc;
        logic [15:0]   xo;

        delay_line_param #(
            .DATA_W(16), .MAX_DEPTH(M), .DEF_DLY(DEF), .CNT_W(CW)
        ) dut (
            .CLK(CLK), .RST(RST), .Xin(xin), .Xin_VALID(xin_valid),
            .DLY_LEN(dly_len[CW-1:0]), .DLY_LOAD(dly_load),
            .Xout(xo), .Xout_VALID(xvalid_w[g]), .PRIMED(primed_w[g]), .DLY_CUR(dc)
        );
        assign xout_w[g]    = xo;
        assign dly_cur_w[g] = 8'(dc);

        // Model: every sample accepted since reset/load, and the delay in force.
        logic signed [15:0] hist[$];
        int                 d_m;
        int                 len;
        logic signed [15:0] ex_x;
        logic               ex_v;
        logic               ex_p;

        always @(posedge CLK) begin
            if (RST) begin
                hist.delete();
                d_m  = DEF;
                ex_x = 16'sd0;
                ex_v = 1'b0;
                ex_p = 1'b0;
            end else begin
                if (dly_load) begin
                    len = int'(dly_len) % (1 << CW);
                    d_m = (len == 0) ? 1 : ((len > M) ? M : len);
                    hist.delete();
                    ex_p = 1'b0;
                end
                ex_v = xin_valid;
                if (xin_valid) begin
                    hist.push_back(xin);
                    if (hist.size() - 1 >= d_m) begin
                        ex_x = hist[hist.size() - 1 - d_m];
                        ex_p = 1'b1;
                    end else begin
                        ex_x = 16'sd0;
                        ex_p = 1'b0;
                    end
                end
            end
        end

        always @(negedge CLK) begin
            if (armed) begin
                check($sformatf("model_xout%0d", g), xout_w[g], ex_x);
                check($sformatf("model_xvalid%0d", g), {31'd0, xvalid_w[g]}, {31'd0, ex_v});
                check($sformatf("model_primed%0d", g), {31'd0, primed_w[g]}, {31'd0, ex_p});
                check($sformatf("model_dlycur%0d", g), {24'd0, dly_cur_w[g]}, d_m);
            end
        end
    end

    task automatic cyc(input int x, input bit v, input bit ld, input int l, input bit r);
        xin       = 16'(x);
        xin_valid = v;
        dly_load  = ld;
        dly_len   = 8'(l);
        RST       = r;
        @(posedge CLK);
        #1;
        xin_valid = 1'b0;
        dly_load  = 1'b0;
        RST       = 1'b0;
    endtask

    initial begin
        RST = 1'b1; xin = '0; xin_valid = 1'b0; dly_len = '0; dly_load = 1'b0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        armed = 1'b1;
        check("rst_dlycur0", dly_cur_w[0], 120);
        check("rst_dlycur1", dly_cur_w[1], 100);
        check("rst_xout0", xout_w[0], 0);
        check("rst_primed0", primed_w[0], 0);
        check("rst_xvalid0", xvalid_w[0], 0);

        for (int n = 1; n <= 300; n++) begin
            cyc(n, 1, 0, 0, 0);
            if (n == 101) check("ramp101_xout1", xout_w[1], 1);
            if (n == 120) begin check("ramp120_xout0", xout_w[0], 0); check("ramp120_primed0", primed_w[0], 0); end
            if (n == 121) begin check("ramp121_xout0", xout_w[0], 1); check("ramp121_primed0", primed_w[0], 1); end
            if (n == 300) check("ramp300_xout0", xout_w[0], 180);
        end
        cyc(0, 0, 0, 0, 0);
        check("idle_xvalid0", xvalid_w[0], 0);
        check("idle_hold0", xout_w[0], 180);

        cyc(0, 0, 1, 5, 0);
        check("ld5_dlycur0", dly_cur_w[0], 5);
        check("ld5_primed0", primed_w[0], 0);
        for (int k = 0; k < 20; k++) begin
            cyc(-(k + 1), 1, 0, 0, 0);
            if (k == 5) check("gap_k5_xout0", xout_w[0], -1);
            cyc(0, 0, 0, 0, 0);
            if (k == 5) check("gap_k5_hold0", xout_w[0], -1);
        end
        check("gap_k19_xout0", xout_w[0], -15);

        cyc(7, 1, 1, 0, 0);
        check("ld0_dlycur0", dly_cur_w[0], 1);
        check("ld0_first_xout0", xout_w[0], 0);
        cyc(8, 1, 0, 0, 0);
        check("ld0_prev_xout0", xout_w[0], 7);
        cyc(9, 1, 0, 0, 0);
        check("ld0_prev2_xout0", xout_w[0], 8);

        for (int i = 0; i < 384; i++) begin
            cyc(1000 + i, 1, (i == 0), 200, 0);
            if (i == 0)   check("ld200_dlycur0", dly_cur_w[0], 128);
            if (i == 127) check("max_i127_xout0", xout_w[0], 0);
            if (i == 128) check("max_i128_xout0", xout_w[0], 1000);
            if (i == 383) check("max_i383_xout0", xout_w[0], 1255);
        end

        cyc(0, 0, 1, 120, 0);
        for (int i = 0; i < 150; i++) cyc(2000 + i, 1, 0, 0, 0);
        check("pre_reload_xout0", xout_w[0], 2029);
        cyc(5000, 1, 1, 10, 0);
        check("reload_xout0", xout_w[0], 0);
        check("reload_primed0", primed_w[0], 0);
        check("reload_dlycur0", dly_cur_w[0], 10);
        for (int j = 1; j <= 10; j++) begin
            cyc(5000 + j, 1, 0, 0, 0);
            if (j == 9)  check("reload_j9_xout0", xout_w[0], 0);
            if (j == 10) check("reload_j10_xout0", xout_w[0], 5000);
        end

        for (int i = 0; i < 20; i++) cyc(6000 + i, 1, 0, 0, 0);
        cyc(7777, 1, 1, 3, 1);
        check("midrst_xout0", xout_w[0], 0);
        check("midrst_primed0", primed_w[0], 0);
        check("midrst_dlycur0", dly_cur_w[0], 120);
        check("midrst_dlycur1", dly_cur_w[1], 100);
        for (int i = 1; i <= 130; i++) begin
            cyc(i, 1, 0, 0, 0);
            if (i == 120) check("postrst120_xout0", xout_w[0], 0);
            if (i == 121) check("postrst121_xout0", xout_w[0], 1);
        end

        cyc(0, 0, 1, 3, 0);
        for (int i = 0; i < 10; i++) begin
            cyc((i % 2 == 0) ? 32767 : -32768, 1, 0, 0, 0);
            if (i == 3) check("fs3_xout0", xout_w[0], 32767);
            if (i == 4) check("fs4_xout0", xout_w[0], -32768);
        end
        cyc(0, 0, 1, 100, 0);
        for (int i = 0; i < 250; i++) begin
            cyc((i % 2 == 0) ? 32767 : -32768, 1, 0, 0, 0);
            if (i == 99)  check("fs100_i99_primed1", primed_w[1], 0);
            if (i == 100) begin check("fs100_i100_xout1", xout_w[1], 32767); check("fs100_i100_xout0", xout_w[0], 32767); end
            if (i == 201) check("fs100_i201_xout1", xout_w[1], -32768);
        end
        cyc(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_param.md
Name: delay_line_param

Overview:
- Parametrised, runtime-programmable sample delay line for the EMD signal path. It is the successor to the fixed 120-tap 16-bit shift-register delay.
- Delays a signed sample stream by D valid samples, where 1 <= D <= MAX_DEPTH.
- Storage is a circular buffer rather than a shift chain, with a per-sample valid strobe.
- Outputs are zero-gated until the line is primed.
- Used to time-align the raw signal against the envelope/mean branches when the sifting filters change length.

Parameters:
- DATA_W, 16: sample width, two's complement.
- MAX_DEPTH, 128: buffer entries and maximum delay. Any integer >= 2; need not be a power of two.
- DEF_DLY, 120: delay loaded at reset. Must satisfy 1 <= DEF_DLY <= MAX_DEPTH.
- CNT_W, $clog2(MAX_DEPTH+1): width of the delay and fill counters.

Ports:
- CLK, in, 1: single clock; all logic is rising-edge.
- RST, in, 1: synchronous, active-high reset.
- Xin, in, DATA_W: signed input sample.
- Xin_VALID, in, 1: Xin is a new sample this cycle.
- DLY_LEN, in, CNT_W: requested delay in samples.
- DLY_LOAD, in, 1: one-cycle strobe that applies DLY_LEN.
- Xout, out, DATA_W: signed delayed sample, registered.
- Xout_VALID, out, 1: Xout updated this cycle.
- PRIMED, out, 1: Xout carries real delayed data rather than fill zeros.
- DLY_CUR, out, CNT_W: delay currently in force.

Behaviour:
- Reset (RST=1 at an edge):
  - Xout=0, Xout_VALID=0, PRIMED=0, DLY_CUR=DEF_DLY.
  - wr_ptr=0, fill_cnt=0.
  - RAM contents are not cleared; zero-gating covers them.
  - Reset mid-stream discards all buffered samples.
- Delay load: when DLY_LOAD=1, DLY_CUR <= clamp(DLY_LEN).
  - DLY_LEN=0 gives 1; DLY_LEN>MAX_DEPTH gives MAX_DEPTH.
  - fill_cnt <= 0 and PRIMED <= 0, so the line re-primes.
  - wr_ptr is not reset.
  - DLY_LEN is ignored when DLY_LOAD=0.
- Sample path: on an edge with Xin_VALID=1:
  - mem[wr_ptr] <= Xin.
  - Read address rd = (wr_ptr - D) mod MAX_DEPTH, where D is the delay in force. The read is read-before-write, so D=MAX_DEPTH returns the old mem[wr_ptr].
  - wr_ptr wraps from MAX_DEPTH-1 to 0.
  - If fill_cnt >= D: Xout <= mem[rd] and PRIMED <= 1. Otherwise Xout <= 0 and PRIMED <= 0.
  - fill_cnt <= min(fill_cnt+1, D); it saturates.
- Idle cycles: on an edge with Xin_VALID=0, Xout and PRIMED hold and Xout_VALID <= 0.
- Latency and timing:
  - Xout_VALID is Xin_VALID delayed one CLK.
  - The k-th valid input after reset or load (k from 0) produces Xout = x[k-D] one cycle later if k >= D, otherwise 0.
  - Gaps in Xin_VALID do not alter the sample-count delay.
- Simultaneous DLY_LOAD and Xin_VALID:
  - The new D applies to this sample, and fill_cnt is treated as 0 first.
  - The sample is written, output is 0, and fill_cnt becomes 1.
- Simultaneous RST with anything: RST wins.
- Arithmetic: pure storage; no scaling, rounding or sign change. Xout is bit-exact to the stored Xin.

Decomposition:
- Shared include emd_defs.vh:
  - EMD_DATA_W=16 and EMD_DEF_DLY=120.
  - Clamp macro/function for delay values.
- One sub-module, delay_ram: simple dual-port RAM, DATA_W x MAX_DEPTH.
  - One write port and one synchronous read port.
  - Read-before-write on address collision.
  - Inferable as block RAM or LUT RAM.
- The top level holds the pointer, fill counter, clamp and gating.

Test Plan:
- Reset defaults, then ramp: after RST, feed Xin=1..300 with Xin_VALID every cycle.
  - Outputs 1..120 are 0 with PRIMED=0.
  - Output 121 = 1 and PRIMED rises with it; output n = n-120 thereafter.
  - Xout_VALID lags Xin_VALID by exactly 1 cycle.
- Gapped valid: DLY_LOAD with DLY_LEN=5, then Xin=-1,-2,... with Xin_VALID on alternate cycles.
  - Xout = x[k-5] counted in valid samples, not cycles.
  - Xout holds during gaps with Xout_VALID=0.
- Clamp and extremes:
  - DLY_LEN=0 gives DLY_CUR=1, and output equals the previous sample.
  - DLY_LEN=200 gives DLY_CUR=128; wrap is correct over 3*128 samples.
  - Read-before-write holds at D=MAX_DEPTH.
- Mid-stream reload: while primed at D=120, pulse DLY_LOAD=10 together with Xin_VALID.
  - That output is 0 with PRIMED=0.
  - The next 9 outputs are 0; the 11th equals the sample loaded at the DLY_LOAD cycle.
- Reset mid-operation: assert RST for 1 cycle during a primed stream.
  - Xout=0, PRIMED=0, DLY_CUR=120.
  - No pre-reset sample ever reappears at the output.
- Full-scale data: alternate 16'h7FFF and 16'h8000 at D=3.
  - Bit-exact delayed copy with sign preserved.
  - Rerun with MAX_DEPTH=100 (non-power-of-two) at D=100.
